// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register between the ALU stage and the data-memory stage.
// Supports hold (stall), bubble insertion (flush), a valid bit, store-data
// forwarding from writeback, and saturating stall/flush event counters.
module ex_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] pc_next_in,
  input  logic [REG_W-1:0]  rs_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic              memwrite_in,
  input  logic              memread_in,
  input  logic              regwrite_in,
  input  logic              branch_in,
  input  logic              memtoreg_in,
  input  logic              jump_in,
  input  logic              fwd_en,
  input  logic              wb_regwrite,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              valid_exe,
  output logic [DATA_W-1:0] pc_next_exe,
  output logic [DATA_W-1:0] alu_result_exe,
  output logic [DATA_W-1:0] store_data_exe,
  output logic [REG_W-1:0]  rs_exe,
  output logic [REG_W-1:0]  rt_exe,
  output logic [REG_W-1:0]  rd_exe,
  output logic              memwrite_exe,
  output logic              memread_exe,
  output logic              regwrite_exe,
  output logic              branch_exe,
  output logic              memtoreg_exe,
  output logic              jump_exe,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              w_load;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_store_data;
  logic [5:0]        w_ctrl_in;

  logic              r_valid_p0;
  logic [5:0]        r_ctrl_p0;
  logic [DATA_W-1:0] r_pc_next_p0;
  logic [DATA_W-1:0] r_alu_result_p0;
  logic [DATA_W-1:0] r_store_data_p0;
  logic [REG_W-1:0]  r_rs_p0;
  logic [REG_W-1:0]  r_rt_p0;
  logic [REG_W-1:0]  r_rd_p0;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  assign w_load    = !flush && !stall;
  // Register 0 is hard-wired zero, so a writeback to it is never forwarded.
  assign w_fwd_hit = fwd_en && wb_regwrite && (wb_rd != '0) && (wb_rd == rt_in);
  assign w_store_data = w_fwd_hit ? wb_data : store_data_in;
  // Bubbles from EX must never carry live control (memwrite/regwrite etc).
  assign w_ctrl_in = {memwrite_in, memread_in, regwrite_in,
                      branch_in, memtoreg_in, jump_in} & {6{in_valid}};

  // EX -> MEM boundary: valid and control bits (flush clears, stall holds).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_p0 <= 1'b0;
      r_ctrl_p0  <= '0;
    end else if (flush) begin
      r_valid_p0 <= 1'b0;
      r_ctrl_p0  <= '0;
    end else if (w_load) begin
      r_valid_p0 <= in_valid;
      r_ctrl_p0  <= w_ctrl_in;
    end
  end

  // EX -> MEM boundary: data and specifiers (flush and stall both hold).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_next_p0    <= '0;
      r_alu_result_p0 <= '0;
      r_store_data_p0 <= '0;
      r_rs_p0         <= '0;
      r_rt_p0         <= '0;
      r_rd_p0         <= '0;
    end else if (w_load) begin
      r_pc_next_p0    <= pc_next_in;
      r_alu_result_p0 <= alu_result_in;
      r_store_data_p0 <= w_store_data;
      r_rs_p0         <= rs_in;
      r_rt_p0         <= rt_in;
      r_rd_p0         <= rd_in;
    end
  end

  // Debug event counters; a flush masks a simultaneous stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (flush) begin
      r_flush_cnt <= sat_inc(r_flush_cnt);
    end else if (stall) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign valid_exe      = r_valid_p0;
  assign pc_next_exe    = r_pc_next_p0;
  assign alu_result_exe = r_alu_result_p0;
  assign store_data_exe = r_store_data_p0;
  assign rs_exe         = r_rs_p0;
  assign rt_exe         = r_rt_p0;
  assign rd_exe         = r_rd_p0;
  assign memwrite_exe   = r_ctrl_p0[5];
  assign memread_exe    = r_ctrl_p0[4];
  assign regwrite_exe   = r_ctrl_p0[3];
  assign branch_exe     = r_ctrl_p0[2];
  assign memtoreg_exe   = r_ctrl_p0[1];
  assign jump_exe       = r_ctrl_p0[0];
  assign stall_cnt      = r_stall_cnt;
  assign flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: a behavioural model predicts each
// cycle's outputs into a scoreboard queue, popped and compared after the edge.
module tb_ex_mem_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid;
  logic [31:0] pc_in, alu_in, sd_in, wb_data;
  logic [4:0]  rs_in, rt_in, rd_in, wb_rd;
  logic        mw, mr, rw, br, mtr, jp;
  logic        fwd_en, wb_regwrite;

  logic        valid_exe;
  logic [31:0] pc_exe, alu_exe, sd_exe;
  logic [4:0]  rs_exe, rt_exe, rd_exe;
  logic        mw_exe, mr_exe, rw_exe, br_exe, mtr_exe, jp_exe;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_valid;
  logic [31:0] s_pc, s_alu, s_sd;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic        s_mw, s_mr, s_rw, s_br, s_mtr, s_jp;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_reg #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .pc_next_in(pc_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .alu_result_in(alu_in), .store_data_in(sd_in),
    .memwrite_in(mw), .memread_in(mr), .regwrite_in(rw), .branch_in(br),
    .memtoreg_in(mtr), .jump_in(jp),
    .fwd_en(fwd_en), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .valid_exe(valid_exe), .pc_next_exe(pc_exe), .alu_result_exe(alu_exe),
    .store_data_exe(sd_exe), .rs_exe(rs_exe), .rt_exe(rt_exe), .rd_exe(rd_exe),
    .memwrite_exe(mw_exe), .memread_exe(mr_exe), .regwrite_exe(rw_exe),
    .branch_exe(br_exe), .memtoreg_exe(mtr_exe), .jump_exe(jp_exe),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  ex_mem_pipe_reg #(.DATA_W(32), .REG_W(5), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .pc_next_in(pc_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .alu_result_in(alu_in), .store_data_in(sd_in),
    .memwrite_in(mw), .memread_in(mr), .regwrite_in(rw), .branch_in(br),
    .memtoreg_in(mtr), .jump_in(jp),
    .fwd_en(fwd_en), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .valid_exe(s_valid), .pc_next_exe(s_pc), .alu_result_exe(s_alu),
    .store_data_exe(s_sd), .rs_exe(s_rs), .rt_exe(s_rt), .rd_exe(s_rd),
    .memwrite_exe(s_mw), .memread_exe(s_mr), .regwrite_exe(s_rw),
    .branch_exe(s_br), .memtoreg_exe(s_mtr), .jump_exe(s_jp),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc, alu, sd;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  ctrl;
    logic [15:0] sc, fc;
  } exp_t;

  exp_t q[$];
  exp_t m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s mismatch", tag);
    end
  endtask

  // Reference behaviour: rst > flush > stall > load.
  function automatic exp_t model_next(input exp_t cur);
    exp_t n = cur;
    if (rst) begin
      n.v = 1'b0; n.pc = '0; n.alu = '0; n.sd = '0;
      n.rs = '0; n.rt = '0; n.rd = '0; n.ctrl = '0; n.sc = '0; n.fc = '0;
    end else if (flush) begin
      n.v = 1'b0;
      n.ctrl = '0;
      if (cur.fc != 16'hFFFF) n.fc = cur.fc + 16'd1;
    end else if (stall) begin
      if (cur.sc != 16'hFFFF) n.sc = cur.sc + 16'd1;
    end else begin
      n.v   = in_valid;
      n.pc  = pc_in;
      n.alu = alu_in;
      n.rs  = rs_in;
      n.rt  = rt_in;
      n.rd  = rd_in;
      n.ctrl = in_valid ? {mw, mr, rw, br, mtr, jp} : 6'b0;
      if (fwd_en && wb_regwrite && wb_rd != 5'd0 && wb_rd == rt_in) n.sd = wb_data;
      else n.sd = sd_in;
    end
    return n;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue observed=empty expected=entry", tag);
      return;
    end
    e = q.pop_front();
    chk({tag, "_valid"}, 64'(valid_exe), 64'(e.v));
    chk({tag, "_pc"},    64'(pc_exe),    64'(e.pc));
    chk({tag, "_alu"},   64'(alu_exe),   64'(e.alu));
    chk({tag, "_sd"},    64'(sd_exe),    64'(e.sd));
    chk({tag, "_rs"},    64'(rs_exe),    64'(e.rs));
    chk({tag, "_rt"},    64'(rt_exe),    64'(e.rt));
    chk({tag, "_rd"},    64'(rd_exe),    64'(e.rd));
    chk({tag, "_ctrl"},  64'({mw_exe, mr_exe, rw_exe, br_exe, mtr_exe, jp_exe}), 64'(e.ctrl));
    chk({tag, "_scnt"},  64'(stall_cnt), 64'(e.sc));
    chk({tag, "_fcnt"},  64'(flush_cnt), 64'(e.fc));
  endtask

  // Predict, clock once, then compare one time unit after the edge.
  task automatic step(input string tag);
    m = model_next(m);
    q.push_back(m);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic set_load(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [5:0] ctrl);
    in_valid = v; pc_in = pc; alu_in = alu; sd_in = sd;
    rs_in = rs; rt_in = rt; rd_in = rd;
    {mw, mr, rw, br, mtr, jp} = ctrl;
  endtask

  initial begin
    m = '{v: 1'b0, pc: '0, alu: '0, sd: '0, rs: '0, rt: '0, rd: '0, ctrl: '0, sc: '0, fc: '0};
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    fwd_en = 1'b0; wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
    set_load(1'b1, 32'h40, 32'h1234, 32'h77, 5'd3, 5'd4, 5'd5, 6'b111111);

    // Reset held while live inputs are presented.
    step("rst0");
    step("rst1");
    chk("rst_alu", 64'(alu_exe), 64'h0);
    chk("rst_valid", 64'(valid_exe), 64'h0);
    chk("rst_sat_scnt", 64'(s_stall_cnt), 64'h0);

    // Valid load, then a bubble load.
    rst = 1'b0;
    set_load(1'b1, 32'h100, 32'hDEADBEEF, 32'h55, 5'd1, 5'd2, 5'd7, 6'b101000);
    step("load_v");
    chk("load_v_alu", 64'(alu_exe), 64'hDEADBEEF);
    chk("load_v_rd", 64'(rd_exe), 64'd7);
    chk("load_v_rw", 64'(rw_exe), 64'd1);
    chk("load_v_mw", 64'(mw_exe), 64'd1);
    set_load(1'b0, 32'h104, 32'hA5A5A5A5, 32'h66, 5'd8, 5'd9, 5'd10, 6'b111111);
    step("load_b");
    chk("load_b_valid", 64'(valid_exe), 64'd0);
    chk("load_b_mw", 64'(mw_exe), 64'd0);
    chk("load_b_alu", 64'(alu_exe), 64'hA5A5A5A5);

    // Three stall cycles with changing inputs, then release.
    set_load(1'b1, 32'h200, 32'h600D, 32'h99, 5'd11, 5'd12, 5'd13, 6'b010101);
    step("pre_stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_load(i[0], 32'h300 + 32'(i), 32'hBAD0 + 32'(i), 32'h1000 + 32'(i),
               5'd20, 5'd21, 5'(22 + i), 6'(i + 40));
      step("stall");
    end
    chk("stall_alu_frozen", 64'(alu_exe), 64'h600D);
    chk("stall_cnt3", 64'(stall_cnt), 64'd3);
    stall = 1'b0;
    set_load(1'b1, 32'h400, 32'h0BEEF, 32'h12, 5'd14, 5'd15, 5'd16, 6'b000110);
    step("release");
    chk("release_alu", 64'(alu_exe), 64'h0BEEF);

    // Flush together with stall after a valid memwrite load.
    set_load(1'b1, 32'h500, 32'h4444, 32'h34, 5'd17, 5'd18, 5'd19, 6'b100000);
    step("pre_flush");
    flush = 1'b1; stall = 1'b1;
    set_load(1'b1, 32'h600, 32'h5555, 32'h56, 5'd1, 5'd1, 5'd1, 6'b111111);
    step("flush");
    chk("flush_valid", 64'(valid_exe), 64'd0);
    chk("flush_mw", 64'(mw_exe), 64'd0);
    chk("flush_alu", 64'(alu_exe), 64'h4444);
    chk("flush_fcnt", 64'(flush_cnt), 64'd1);
    chk("flush_scnt", 64'(stall_cnt), 64'd3);
    flush = 1'b0; stall = 1'b0;

    // Store-data forwarding: hit, register 0, disabled.
    fwd_en = 1'b1; wb_regwrite = 1'b1; wb_rd = 5'd9; wb_data = 32'hCAFE0000;
    set_load(1'b1, 32'h700, 32'h1, 32'h11, 5'd2, 5'd9, 5'd3, 6'b100000);
    step("fwd_hit");
    chk("fwd_hit_sd", 64'(sd_exe), 64'hCAFE0000);
    wb_rd = 5'd0;
    set_load(1'b1, 32'h704, 32'h2, 32'h11, 5'd2, 5'd0, 5'd3, 6'b100000);
    step("fwd_r0");
    chk("fwd_r0_sd", 64'(sd_exe), 64'h11);
    wb_rd = 5'd9; fwd_en = 1'b0;
    set_load(1'b1, 32'h708, 32'h3, 32'h11, 5'd2, 5'd9, 5'd3, 6'b100000);
    step("fwd_off");
    chk("fwd_off_sd", 64'(sd_exe), 64'h11);
    // Held data is not re-forwarded during a stall.
    fwd_en = 1'b1; stall = 1'b1;
    step("fwd_stall");
    chk("fwd_stall_sd", 64'(sd_exe), 64'h11);
    stall = 1'b0; wb_regwrite = 1'b0;

    // Saturation on the 3-bit counter instance, then reset mid-stall/flush.
    rst = 1'b1;
    step("sat_rst");
    rst = 1'b0; stall = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step("sat");
      if (i == 7) chk("sat_at7", 64'(s_stall_cnt), 64'd7);
    end
    chk("sat_hold7", 64'(s_stall_cnt), 64'd7);
    chk("sat_wide10", 64'(stall_cnt), 64'd10);
    rst = 1'b1; flush = 1'b1;
    step("sat_clr");
    chk("sat_clr_scnt", 64'(s_stall_cnt), 64'd0);
    chk("sat_clr_fcnt", 64'(s_flush_cnt), 64'd0);
    rst = 1'b0; flush = 1'b0; stall = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
